// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: scan-code set 2 constants, decode state encoding,
// key bit positions and the small decode/parity helpers used by the receiver and decoder.
package ps2_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_ARR_U  = 8'h75;
  localparam logic [7:0] SC_ARR_D  = 8'h72;
  localparam logic [7:0] SC_ARR_R  = 8'h74;
  localparam logic [7:0] SC_ARR_L  = 8'h6B;
  localparam logic [7:0] SC_W      = 8'h1D;
  localparam logic [7:0] SC_S      = 8'h1B;
  localparam logic [7:0] SC_D      = 8'h23;
  localparam logic [7:0] SC_A      = 8'h1C;

  localparam int KEY_U = 3;
  localparam int KEY_D = 2;
  localparam int KEY_R = 1;
  localparam int KEY_L = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_t;

  // bits[0]=start, bits[8:1]=data, bits[9]=parity; odd parity over data+parity.
  function automatic logic frame_ok(input logic [9:0] bits, input logic stop);
    return (bits[0] == 1'b0) && (stop == 1'b1) && (^bits[9:1] == 1'b1);
  endfunction

  function automatic logic [3:0] map_ext(input logic [7:0] code);
    logic [3:0] m;
    m = 4'b0000;
    case (code)
      SC_ARR_U: m[KEY_U] = 1'b1;
      SC_ARR_D: m[KEY_D] = 1'b1;
      SC_ARR_R: m[KEY_R] = 1'b1;
      SC_ARR_L: m[KEY_L] = 1'b1;
      default:  m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] map_std(input logic [7:0] code);
    logic [3:0] m;
    m = 4'b0000;
    case (code)
      SC_W:    m[KEY_U] = 1'b1;
      SC_S:    m[KEY_D] = 1'b1;
      SC_D:    m[KEY_R] = 1'b1;
      SC_A:    m[KEY_L] = 1'b1;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: pin synchronisers, clock glitch filter,
// falling-edge framing with parity check and partial-frame timeout.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 80000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic [3:0]    bit_cnt;
  logic [9:0]    shift;
  logic [TW-1:0] idle_cnt;

  // Two-flop synchronisers for both asynchronous pins
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
        fall     <= clk_filt;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Frame assembly; the 11th bit is checked against stop directly from the data pin
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= 4'd0;
      shift     <= 10'd0;
      idle_cnt  <= '0;
      rx_byte   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          if (frame_ok(shift, data_sync[1])) begin
            rx_byte  <= shift[8:1];
            rx_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          shift   <= {data_sync[1], shift[9:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        // A stalled partial frame is dropped silently
        if (idle_cnt == TW'(TIMEOUT - 1)) begin
          bit_cnt  <= 4'd0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_keys_decoder.sv
// PS/2 keyboard to {U,D,R,L} held-key flags: arrows (E0-prefixed) and WASD
// are tracked separately and ORed onto the registered keys output.
module ps2_keys_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 80000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] keys,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  dec_state_t state, state_nxt;
  logic [3:0] arrow_held, arrow_nxt;
  logic [3:0] wasd_held, wasd_nxt;

  ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  // Decode state and held-key registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      arrow_held <= 4'b0000;
      wasd_held  <= 4'b0000;
      keys       <= 4'b0000;
    end else begin
      state      <= state_nxt;
      arrow_held <= arrow_nxt;
      wasd_held  <= wasd_nxt;
      keys       <= arrow_nxt | wasd_nxt;
    end
  end

  // Make/break sequencing; a bad frame only drops any pending prefix
  always_comb begin
    state_nxt = state;
    arrow_nxt = arrow_held;
    wasd_nxt  = wasd_held;
    if (frame_err) begin
      state_nxt = ST_IDLE;
    end else if (rx_valid) begin
      case (state)
        ST_IDLE: begin
          if (rx_byte == SC_EXT) begin
            state_nxt = ST_EXT;
          end else if (rx_byte == SC_BRK) begin
            state_nxt = ST_BRK;
          end else begin
            wasd_nxt = wasd_held | map_std(rx_byte);
          end
        end
        ST_EXT: begin
          if (rx_byte == SC_BRK) begin
            state_nxt = ST_EXT_BRK;
          end else if (rx_byte == SC_EXT) begin
            state_nxt = ST_EXT;
          end else begin
            arrow_nxt = arrow_held | map_ext(rx_byte);
            state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          wasd_nxt  = wasd_held & ~map_std(rx_byte);
          state_nxt = ST_IDLE;
        end
        ST_EXT_BRK: begin
          arrow_nxt = arrow_held & ~map_ext(rx_byte);
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt = state;
    end
  end

endmodule

// File: tb/tb_ps2_keys_decoder.sv
// Directed bench for ps2_keys_decoder: a bit-level PS/2 device model drives
// frames and each scenario task checks keys / rx_byte / pulse counts inline.
module tb_ps2_keys_decoder;

  localparam int TB_TIMEOUT = 2000;
  localparam int HALF       = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] keys;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;

  int vectors = 0;
  int miscompares = 0;

  int         rv_cnt = 0;
  int         fe_cnt = 0;
  logic       rv_d = 1'b0;
  logic [3:0] keys_at_valid = 4'b0000;
  logic [3:0] keys_after_valid = 4'b0000;

  ps2_keys_decoder #(.FILTER_LEN(8), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keys      (keys),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Pulse counters and keys snapshots around each rx_valid
  always @(negedge clk) begin
    if (rv_d) keys_after_valid = keys;
    if (rx_valid) begin
      keys_at_valid = keys;
      rv_cnt = rv_cnt + 1;
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
    rv_d = rx_valid;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Device-side frame: start, D0..D7, parity (odd unless bad_par), stop; first nbits only
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      cycles(HALF / 2);
      ps2_clk = 1'b0;
      cycles(HALF);
      ps2_clk = 1'b1;
      cycles(HALF / 2);
    end
    ps2_data = 1'b1;
    cycles(HALF);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 11);
  endtask

  task automatic test_reset;
    cycles(5);
    rst = 1'b0;
    cycles(2);
    vectors++;
    if (keys !== 4'b0000) begin
      $display("FAIL reset_keys got=%b want=%b", keys, 4'b0000); miscompares++;
    end
    vectors++;
    if (rx_byte !== 8'h00 || rx_valid !== 1'b0 || frame_err !== 1'b0) begin
      $display("FAIL reset_outs got byte=%h v=%b e=%b want 00/0/0", rx_byte, rx_valid, frame_err);
      miscompares++;
    end
  endtask

  task automatic test_arrow_up;
    send(8'hE0);
    vectors++;
    if (keys !== 4'b0000) begin
      $display("FAIL t1_prefix got=%b want=%b", keys, 4'b0000); miscompares++;
    end
    send(8'h75);
    vectors++;
    if (keys_at_valid !== 4'b0000 || keys_after_valid !== 4'b1000) begin
      $display("FAIL t1_latency got at=%b after=%b want 0000/1000", keys_at_valid, keys_after_valid);
      miscompares++;
    end
    vectors++;
    if (rx_byte !== 8'h75) begin
      $display("FAIL t1_byte got=%h want=%h", rx_byte, 8'h75); miscompares++;
    end
    send(8'hE0); send(8'hF0); send(8'h75);
    vectors++;
    if (keys !== 4'b0000) begin
      $display("FAIL t1_break got=%b want=%b", keys, 4'b0000); miscompares++;
    end
  endtask

  task automatic test_overlap;
    send(8'h1C);
    vectors++;
    if (keys !== 4'b0001) begin
      $display("FAIL t2_a got=%b want=%b", keys, 4'b0001); miscompares++;
    end
    send(8'hE0); send(8'h6B);
    send(8'hF0); send(8'h1C);
    vectors++;
    if (keys !== 4'b0001) begin
      $display("FAIL t2_arrow_held got=%b want=%b", keys, 4'b0001); miscompares++;
    end
    send(8'hE0); send(8'hF0); send(8'h6B);
    vectors++;
    if (keys !== 4'b0000) begin
      $display("FAIL t2_release got=%b want=%b", keys, 4'b0000); miscompares++;
    end
  endtask

  task automatic test_parity_err;
    int rv0, fe0;
    rv0 = rv_cnt; fe0 = fe_cnt;
    send_frame(8'h23, 1'b1, 11);
    vectors++;
    if (fe_cnt - fe0 !== 1 || rv_cnt !== rv0) begin
      $display("FAIL t3_err_pulse got fe=%0d rv=%0d want 1/0", fe_cnt - fe0, rv_cnt - rv0);
      miscompares++;
    end
    vectors++;
    if (keys !== 4'b0000 || rx_byte !== 8'h6B) begin
      $display("FAIL t3_held got keys=%b byte=%h want 0000/6b", keys, rx_byte); miscompares++;
    end
    send(8'hE0); send(8'h74);
    vectors++;
    if (keys !== 4'b0010) begin
      $display("FAIL t3_right got=%b want=%b", keys, 4'b0010); miscompares++;
    end
    send(8'hE0); send(8'hF0); send(8'h74);
    // Pending E0 must be dropped by the bad frame, so 1C decodes as A
    send(8'hE0);
    send_frame(8'h23, 1'b1, 11);
    send(8'h1C);
    vectors++;
    if (keys !== 4'b0001) begin
      $display("FAIL t3_stale_prefix got=%b want=%b", keys, 4'b0001); miscompares++;
    end
    send(8'hF0); send(8'h1C);
  endtask

  task automatic test_timeout;
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'hA5, 1'b0, 5);
    cycles(TB_TIMEOUT + 200);
    send(8'h1B);
    vectors++;
    if (rx_byte !== 8'h1B || keys !== 4'b0100) begin
      $display("FAIL t4_timeout got byte=%h keys=%b want 1b/0100", rx_byte, keys); miscompares++;
    end
    vectors++;
    if (fe_cnt !== fe0) begin
      $display("FAIL t4_no_err got=%0d want=%0d", fe_cnt, fe0); miscompares++;
    end
    send(8'hF0); send(8'h1B);
  endtask

  task automatic test_back_to_back;
    int bad;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      send(8'h1D);
      if (keys !== 4'b1000) bad++;
    end
    vectors++;
    if (bad != 0) begin
      $display("FAIL t5_repeat got %0d bad samples want 0", bad); miscompares++;
    end
    send(8'h29);
    vectors++;
    if (keys !== 4'b1000 || rx_byte !== 8'h29) begin
      $display("FAIL t5_unmapped got keys=%b byte=%h want 1000/29", keys, rx_byte); miscompares++;
    end
  endtask

  task automatic test_reset_mid_frame;
    send(8'hE0); send(8'h6B);
    vectors++;
    if (keys !== 4'b1001) begin
      $display("FAIL t6_setup got=%b want=%b", keys, 4'b1001); miscompares++;
    end
    send_frame(8'h1B, 1'b0, 5);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    vectors++;
    if (keys !== 4'b0000 || rx_byte !== 8'h00) begin
      $display("FAIL t6_rst got keys=%b byte=%h want 0000/00", keys, rx_byte); miscompares++;
    end
    send(8'h1C);
    vectors++;
    if (keys !== 4'b0001 || rx_byte !== 8'h1C) begin
      $display("FAIL t6_after got keys=%b byte=%h want 0001/1c", keys, rx_byte); miscompares++;
    end
  endtask

  initial begin
    test_reset;
    test_arrow_up;
    test_overlap;
    test_parity_err;
    test_timeout;
    test_back_to_back;
    test_reset_mid_frame;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
